// File: rtl/fifo_uart_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_sched
//  Description : Drains the capture FIFO into the UART as framed packets:
//                header byte, up to BURST_LEN payload bytes, then a trailer
//                byte holding the payload count. A frame starts on FIFO
//                almost-full or after data has waited TIMEOUT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_sched #(
    parameter logic [7:0]  HEADER    = 8'hA5,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_rd_DATA,
    input  logic       fifo_rd_empty,
    input  logic       fifo_wr_almost_full,
    output logic [7:0] tx_DATA,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       frame_active
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_POP   = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_SEND  = 3'd4;
    localparam logic [2:0] S_TRL   = 3'd5;

    localparam logic [7:0]  c_burst_len = 8'(BURST_LEN);
    localparam logic [15:0] c_timeout   = 16'(TIMEOUT);

    logic [2:0]  r_state;
    logic [15:0] r_wait_cnt;
    logic [7:0]  r_pay_cnt;
    logic [7:0]  r_tx_data;
    logic        r_tx_start;
    logic        r_rd_en;
    logic        r_frame_active;

    logic [2:0]  w_state_nxt;
    logic [15:0] w_wait_nxt;
    logic [7:0]  w_pay_nxt;
    logic [7:0]  w_tx_data_nxt;
    logic        w_tx_start_nxt;
    logic        w_rd_en_nxt;
    logic        w_can_start;
    logic        w_trigger;

    // Every output is a flop. A start is decided one cycle ahead from the
    // current tx_busy; that is safe because tx_busy only rises after a start
    // we issued. The byte-sending states hold while their start is on the
    // wire, then advance, so starts can never be back to back.

    // Next-state, next-output and counter logic
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_nxt     = r_wait_cnt;
        w_pay_nxt      = r_pay_cnt;
        w_tx_data_nxt  = r_tx_data;
        w_tx_start_nxt = 1'b0;
        w_rd_en_nxt    = 1'b0;
        w_can_start    = !tx_busy && !r_tx_start;
        w_trigger      = fifo_wr_almost_full ||
                         (!fifo_rd_empty && (r_wait_cnt == c_timeout));

        case (r_state)
            S_IDLE: begin
                if (fifo_rd_empty) begin
                    w_wait_nxt = 16'd0;
                end else if (r_wait_cnt != c_timeout) begin
                    w_wait_nxt = r_wait_cnt + 16'd1;
                end
                if (w_trigger) begin
                    w_state_nxt   = S_HDR;
                    w_wait_nxt    = 16'd0;
                    w_pay_nxt     = 8'd0;
                    w_tx_data_nxt = HEADER;
                    if (w_can_start) begin
                        w_tx_start_nxt = 1'b1;
                    end
                end
            end
            S_HDR: begin
                if (r_tx_start) begin
                    w_state_nxt = S_POP;
                end else if (w_can_start) begin
                    w_tx_start_nxt = 1'b1;
                end
            end
            S_POP: begin
                if (!tx_busy) begin
                    if (!fifo_rd_empty && (r_pay_cnt < c_burst_len)) begin
                        w_rd_en_nxt = 1'b1;
                        w_state_nxt = S_LATCH;
                    end else begin
                        w_tx_data_nxt = r_pay_cnt;
                        w_state_nxt   = S_TRL;
                    end
                end
            end
            S_LATCH: begin
                // The pop strobe is on the wire this cycle; the word shows up
                // on fifo_rd_DATA next cycle and is captured in SEND.
                w_pay_nxt   = r_pay_cnt + 8'd1;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (r_tx_start) begin
                    w_state_nxt = S_POP;
                end else if (w_can_start) begin
                    w_tx_data_nxt  = fifo_rd_DATA;
                    w_tx_start_nxt = 1'b1;
                end
            end
            S_TRL: begin
                if (r_tx_start) begin
                    w_state_nxt = S_IDLE;
                end else if (w_can_start) begin
                    w_tx_start_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_wait_cnt     <= 16'd0;
            r_pay_cnt      <= 8'd0;
            r_tx_data      <= 8'h00;
            r_tx_start     <= 1'b0;
            r_rd_en        <= 1'b0;
            r_frame_active <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_wait_cnt     <= w_wait_nxt;
            r_pay_cnt      <= w_pay_nxt;
            r_tx_data      <= w_tx_data_nxt;
            r_tx_start     <= w_tx_start_nxt;
            r_rd_en        <= w_rd_en_nxt;
            r_frame_active <= (w_state_nxt != S_IDLE);
        end
    end

    assign fifo_rd_en   = r_rd_en;
    assign tx_DATA      = r_tx_data;
    assign tx_start     = r_tx_start;
    assign frame_active = r_frame_active;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_uart_sched
//  Description : Self-checking bench for fifo_uart_sched with a FIFO model,
//                a UART busy model and a byte scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_sched;

    localparam logic [7:0] c_header   = 8'hA5;
    localparam int         c_burst    = 6;
    localparam int         c_timeout  = 20;
    localparam int         c_depth    = 8;
    localparam int         c_afull    = 6;
    localparam int         c_byte_cyc = 10;

    logic       clk                 = 1'b0;
    logic       rst                 = 1'b1;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_DATA        = 8'h00;
    logic       fifo_rd_empty       = 1'b1;
    logic       fifo_wr_almost_full = 1'b0;
    logic [7:0] tx_DATA;
    logic       tx_start;
    logic       tx_busy;
    logic       frame_active;

    logic       wr_en     = 1'b0;
    logic [7:0] wr_data   = 8'h00;
    logic       uart_busy = 1'b0;
    int         uart_cnt  = 0;
    logic       hold      = 1'b0;
    logic       prev_start = 1'b0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    int n_vec       = 0;
    int n_err       = 0;
    int rx_cnt      = 0;
    int hold_starts = 0;
    int hold_pops   = 0;

    assign tx_busy = uart_busy | hold;

    always #5 clk = ~clk;

    fifo_uart_sched #(
        .HEADER    (c_header),
        .BURST_LEN (c_burst),
        .TIMEOUT   (c_timeout)
    ) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_DATA        (fifo_rd_DATA),
        .fifo_rd_empty       (fifo_rd_empty),
        .fifo_wr_almost_full (fifo_wr_almost_full),
        .tx_DATA             (tx_DATA),
        .tx_start            (tx_start),
        .tx_busy             (tx_busy),
        .frame_active        (frame_active)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // FIFO model: registered read data and flags; contents survive DUT reset
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) fifo_rd_DATA <= fifo_q.pop_front();
        if (wr_en && fifo_q.size() < c_depth) fifo_q.push_back(wr_data);
        fifo_rd_empty       <= (fifo_q.size() == 0);
        fifo_wr_almost_full <= (fifo_q.size() >= c_afull);
    end

    // UART model: busy for c_byte_cyc cycles after each accepted start
    always @(posedge clk) begin
        if (tx_start && !tx_busy) begin
            uart_busy <= 1'b1;
            uart_cnt  <= c_byte_cyc;
        end else if (uart_cnt > 1) begin
            uart_cnt <= uart_cnt - 1;
        end else begin
            uart_busy <= 1'b0;
            uart_cnt  <= 0;
        end
    end

    // Protocol monitor and scoreboard compare
    always @(negedge clk) begin
        if (rst) begin
            check("start_in_reset", int'(tx_start), 0);
        end else begin
            if (tx_start) begin
                check("start_while_busy", int'(tx_busy), 0);
                check("start_back_to_back", int'(prev_start), 0);
                check("frame_active_at_start", int'(frame_active), 1);
                check("sb_has_entry", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("tx_byte", int'(tx_DATA), int'(exp_q.pop_front()));
                rx_cnt++;
            end
            if (fifo_rd_en) check("pop_while_empty", int'(fifo_rd_empty), 0);
            if (hold) begin
                if (tx_start)   hold_starts++;
                if (fifo_rd_en) hold_pops++;
            end
        end
        prev_start = tx_start;
    end

    task automatic push_frame(input logic [7:0] base, input int n);
        exp_q.push_back(c_header);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 8'(i));
        exp_q.push_back(8'(n));
    endtask

    // Writes n consecutive words; t0 is the negedge before the first write edge
    task automatic wr_burst(input int n, input logic [7:0] base, output time t0);
        t0 = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) t0 = $time;
            wr_en   = 1'b1;
            wr_data = base + 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int b = 0;
        while (rx_cnt < n && b < 2000) begin
            @(negedge clk);
            b++;
        end
        check("rx_wait", rx_cnt, n);
    endtask

    task automatic wait_idle();
        int b = 0;
        while ((exp_q.size() != 0 || frame_active || tx_busy || !fifo_rd_empty) && b < 3000) begin
            @(negedge clk);
            b++;
        end
        check("idle_sb_drained", exp_q.size(), 0);
        check("idle_frame_active", int'(frame_active), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"}, int'(fifo_rd_en), 0);
        check({tag, "_tx_start"}, int'(tx_start), 0);
        check({tag, "_tx_data"}, int'(tx_DATA), 0);
        check({tag, "_frame_active"}, int'(frame_active), 0);
    endtask

    initial begin
        int  n;
        int  base;
        time t0;

        // Power-on reset values
        repeat (3) @(negedge clk);
        check_outputs_zero("por");
        rst = 1'b0;

        // Reset while the FIFO holds data: the wait counter must restart
        push_frame(8'h30, 2);
        wr_burst(2, 8'h30, t0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_outputs_zero("rst_hold");
        end
        rst = 1'b0;
        n = 0;
        while (!frame_active && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_restart_latency", n, c_timeout + 1);
        check("rst_restart_hdr_start", int'(tx_start), 1);
        wait_idle();

        // Timeout-triggered frame: write edge is 5 ns after t0, HDR entered
        // TIMEOUT+1 cycles after that, seen at the following negedge
        push_frame(8'h08, 3);
        wr_burst(3, 8'h08, t0);
        n = 0;
        while (!frame_active && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", int'(($time - t0) / 10), c_timeout + 2);
        check("timeout_hdr_byte", int'(tx_DATA), int'(c_header));
        wait_idle();

        // Almost-full trigger: header start one cycle after the flag rises
        push_frame(8'h50, 6);
        wr_burst(6, 8'h50, t0);
        check("afull_seen", int'(fifo_wr_almost_full), 1);
        check("afull_no_start_yet", int'(tx_start), 0);
        @(negedge clk);
        check("afull_hdr_start", int'(tx_start), 1);
        check("afull_frame_active", int'(frame_active), 1);
        wait_idle();

        // Burst limit: 8 words -> 6 in the first frame, 2 in a timeout frame
        push_frame(8'h40, c_burst);
        push_frame(8'h40 + 8'(c_burst), 8 - c_burst);
        wr_burst(8, 8'h40, t0);
        wait_idle();

        // Backpressure: hold busy for 50 cycles after the 2nd payload byte
        base = rx_cnt;
        push_frame(8'h60, 5);
        wr_burst(5, 8'h60, t0);
        wait_rx(base + 3);
        @(negedge clk);
        hold_starts = 0;
        hold_pops   = 0;
        hold        = 1'b1;
        repeat (50) @(negedge clk);
        hold = 1'b0;
        check("hold_no_start", hold_starts, 0);
        check("hold_no_pop", hold_pops, 0);
        n = 0;
        while (!tx_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("resume_latency", n, 3);
        wait_idle();

        // Reset mid-frame: no trailer, next frame restarts its count
        base = rx_cnt;
        exp_q.push_back(c_header);
        exp_q.push_back(8'h70);
        exp_q.push_back(8'h71);
        wr_burst(5, 8'h70, t0);
        wait_rx(base + 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        push_frame(8'h72, 3);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors expected completion", n_vec);
        $fatal(1);
    end

endmodule
`default_nettype wire
